// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - control FSM for a 16-bit-instruction, 8-bit-datapath CPU core
//
// Sequences FETCH -> DECODE -> EXEC -> (WB) for each instruction. It owns the
// program counter, instruction register and flag register. It also drives the
// register-file and ALU control signals for an external datapath.
//
// Ports
//   clk           in   single clock, rising edge
//   rst_n         in   synchronous active-low reset
//   imem_req      out  instruction fetch request (FETCH only)
//   imem_addr     out  fetch address, equal to pc
//   imem_ack      in   fetch data valid, honoured only while imem_req is high
//   imem_rdata    in   instruction word, valid with imem_ack
//   rf_raddr_a    out  register-file read port A, ir[8:6]
//   rf_raddr_b    out  register-file read port B, ir[5:3]
//   alu_op        out  ALU operation code
//   alu_zero      in   ALU Z flag
//   alu_negative  in   ALU N flag
//   alu_carry     in   ALU C flag
//   alu_overflow  in   ALU V flag
//   rf_we         out  register-file write enable (WB only, one cycle)
//   rf_waddr      out  register-file write address, ir[11:9]
//   wb_sel        out  write data source: 0 = ALU result, 1 = imm
//   imm           out  immediate, ir[7:0]
//   flags         out  flag register {Z,N,C,V}
//   halted        out  core stopped until reset

module cpu_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [2:0]  rf_raddr_a,
  output logic [2:0]  rf_raddr_b,
  output logic [2:0]  alu_op,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic        wb_sel,
  output logic [7:0]  imm,
  output logic [3:0]  flags,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_BN   = 4'hA;
  localparam logic [3:0] OP_BC   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic [3:0]  r_flags;
  logic        r_halted;
  logic        r_imem_req;
  logic        r_rf_we;
  logic        r_wb_sel;

  // Instruction decode, all taken from the registered ir.
  logic [3:0] w_opcode;
  logic       w_is_alu;
  logic       w_is_ldi;
  logic       w_is_cmp;
  logic       w_is_jmp;
  logic       w_is_bz;
  logic       w_is_bn;
  logic       w_is_bc;
  logic       w_is_halt;
  logic       w_updates_flags;
  logic       w_writes_rf;
  logic       w_branch_taken;
  logic [7:0] w_imm;
  logic [7:0] w_pc_inc;

  assign w_opcode  = r_ir[15:12];
  assign w_is_alu  = (w_opcode <= 4'h5);
  assign w_is_ldi  = (w_opcode == OP_LDI);
  assign w_is_cmp  = (w_opcode == OP_CMP);
  assign w_is_jmp  = (w_opcode == OP_JMP);
  assign w_is_bz   = (w_opcode == OP_BZ);
  assign w_is_bn   = (w_opcode == OP_BN);
  assign w_is_bc   = (w_opcode == OP_BC);
  assign w_is_halt = (w_opcode == OP_HALT);
  assign w_imm     = r_ir[7:0];

  assign w_updates_flags = w_is_alu | w_is_cmp;
  assign w_writes_rf     = w_is_alu | w_is_ldi;

  // Conditional branches look at the flags registered by an earlier instruction,
  // never at the live ALU flag inputs.
  assign w_branch_taken = (w_is_bz & r_flags[3]) |
                          (w_is_bn & r_flags[2]) |
                          (w_is_bc & r_flags[1]);

  // 8-bit add wraps 0xFF to 0x00 naturally.
  assign w_pc_inc = r_pc + 8'd1;

  // CMP is a subtract whose result is discarded; only its flags are kept.
  always_comb begin
    alu_op = ALU_OP_ADD;
    if (w_is_alu) begin
      alu_op = r_ir[14:12];
    end else if (w_is_cmp) begin
      alu_op = ALU_OP_SUB;
    end
  end

  // Main FSM. imem_req, rf_we, wb_sel and halted are registered and updated on
  // the same edge that enters the state they belong to. Out of reset the FSM
  // sits in FETCH with imem_req low; the first non-reset edge raises imem_req,
  // and an ack is only honoured once the request is actually visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= 8'h00;
      r_ir       <= 16'h0000;
      r_flags    <= 4'b0000;
      r_halted   <= 1'b0;
      r_imem_req <= 1'b0;
      r_rf_we    <= 1'b0;
      r_wb_sel   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_pc       <= w_pc_inc;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end

        S_DECODE: begin
          r_state <= S_EXEC;
        end

        S_EXEC: begin
          if (w_updates_flags) begin
            r_flags <= {alu_zero, alu_negative, alu_carry, alu_overflow};
          end
          if (w_is_jmp || w_branch_taken) begin
            r_pc <= w_imm;
          end
          if (w_writes_rf) begin
            r_rf_we  <= 1'b1;
            r_wb_sel <= w_is_ldi;
            r_state  <= S_WB;
          end else if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        S_WB: begin
          r_rf_we    <= 1'b0;
          r_wb_sel   <= 1'b0;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end

        S_HALT: begin
          // Absorbing: nothing changes until reset.
          r_state <= S_HALT;
        end

        default: begin
          r_imem_req <= 1'b0;
          r_rf_we    <= 1'b0;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign rf_raddr_a = r_ir[8:6];
  assign rf_raddr_b = r_ir[5:3];
  assign rf_waddr   = r_ir[11:9];
  assign imm        = w_imm;
  assign rf_we      = r_rf_we;
  assign wb_sel     = r_wb_sel;
  assign flags      = r_flags;
  assign halted     = r_halted;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - directed self-checking bench for cpu_control_fsm

module tb_cpu_control_fsm;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [2:0]  rf_raddr_a;
  logic [2:0]  rf_raddr_b;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        alu_negative;
  logic        alu_carry;
  logic        alu_overflow;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic        wb_sel;
  logic [7:0]  imm;
  logic [3:0]  flags;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_control_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .rf_raddr_a   (rf_raddr_a),
    .rf_raddr_b   (rf_raddr_b),
    .alu_op       (alu_op),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .wb_sel       (wb_sel),
    .imm          (imm),
    .flags        (flags),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_alu_flags(input logic [3:0] f);
    {alu_zero, alu_negative, alu_carry, alu_overflow} = f;
  endtask

  // Present an instruction with ack in the first requested FETCH cycle.
  task automatic fetch(input logic [15:0] instr);
    imem_rdata = instr;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    set_alu_flags(4'b0000);

    // Reset for two edges.
    tick();
    tick();
    check("rst_pc",       {8'h00, imem_addr}, 16'h0000);
    check("rst_flags",    {12'h000, flags},   16'h0000);
    check("rst_rf_we",    {15'h0, rf_we},     16'h0000);
    check("rst_halted",   {15'h0, halted},    16'h0000);
    check("rst_imem_req", {15'h0, imem_req},  16'h0000);
    rst_n = 1'b1;
    tick();
    check("first_req",  {15'h0, imem_req}, 16'h0001);
    check("first_addr", {8'h00, imem_addr}, 16'h0000);

    // ADD r1,r2,r3 with ALU Z=1.
    set_alu_flags(4'b1000);
    fetch(16'h0298);
    check("add_req_low", {15'h0, imem_req},   16'h0000);
    check("add_pc",      {8'h00, imem_addr},  16'h0001);
    check("add_ra",      {13'h0, rf_raddr_a}, 16'h0002);
    check("add_rb",      {13'h0, rf_raddr_b}, 16'h0003);
    check("add_aluop",   {13'h0, alu_op},     16'h0000);
    tick();
    check("add_exec_flags_old", {12'h000, flags}, 16'h0000);
    check("add_exec_we",        {15'h0, rf_we},   16'h0000);
    tick();
    check("add_wb_we",    {15'h0, rf_we},    16'h0001);
    check("add_wb_waddr", {13'h0, rf_waddr}, 16'h0001);
    check("add_wb_sel",   {15'h0, wb_sel},   16'h0000);
    check("add_flags",    {12'h000, flags},  16'h0008);
    tick();
    check("add_done_we",   {15'h0, rf_we},    16'h0000);
    check("add_done_req",  {15'h0, imem_req}, 16'h0001);
    check("add_done_addr", {8'h00, imem_addr}, 16'h0001);

    // LDI r5,0xA5: flags must ignore the live ALU flags.
    set_alu_flags(4'b0111);
    fetch(16'h6AA5);
    tick();
    tick();
    check("ldi_we",    {15'h0, rf_we},    16'h0001);
    check("ldi_waddr", {13'h0, rf_waddr}, 16'h0005);
    check("ldi_sel",   {15'h0, wb_sel},   16'h0001);
    check("ldi_imm",   {8'h00, imm},      16'h00A5);
    check("ldi_flags", {12'h000, flags},  16'h0008);
    tick();
    check("ldi_next_addr", {8'h00, imem_addr}, 16'h0002);

    // CMP with Z=1 then BZ 0x40: taken.
    set_alu_flags(4'b1000);
    fetch(16'h7000);
    check("cmp_aluop", {13'h0, alu_op}, 16'h0001);
    tick();
    tick();
    check("cmp_3cyc_req", {15'h0, imem_req},  16'h0001);
    check("cmp_addr",     {8'h00, imem_addr}, 16'h0003);
    check("cmp_flags",    {12'h000, flags},   16'h0008);
    check("cmp_no_we",    {15'h0, rf_we},     16'h0000);
    set_alu_flags(4'b0000);
    fetch(16'h9040);
    tick();
    tick();
    check("bz_taken_req",  {15'h0, imem_req},  16'h0001);
    check("bz_taken_addr", {8'h00, imem_addr}, 16'h0040);

    // CMP with Z=0 then BZ: falls through.
    fetch(16'h7000);
    tick();
    tick();
    check("cmp2_flags", {12'h000, flags}, 16'h0000);
    fetch(16'h9040);
    tick();
    tick();
    check("bz_not_taken_addr", {8'h00, imem_addr}, 16'h0042);

    // JMP 0xFF, then delayed ack at pc=0xFF.
    fetch(16'h80FF);
    tick();
    tick();
    check("jmp_addr", {8'h00, imem_addr}, 16'h00FF);
    imem_rdata = 16'hC000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req",  {15'h0, imem_req},  16'h0001);
      check("wait_addr", {8'h00, imem_addr}, 16'h00FF);
    end
    fetch(16'hC000);
    check("wrap_pc", {8'h00, imem_addr}, 16'h0000);
    // Ack outside FETCH must not reload ir.
    imem_ack   = 1'b1;
    imem_rdata = 16'h6E00;
    tick();
    check("ignore_ack_waddr", {13'h0, rf_waddr}, 16'h0000);
    check("ignore_ack_req",   {15'h0, imem_req}, 16'h0000);
    imem_ack = 1'b0;
    tick();
    check("nop_req",  {15'h0, imem_req},  16'h0001);
    check("nop_addr", {8'h00, imem_addr}, 16'h0000);

    // Reset in the middle of WB.
    fetch(16'h6AA5);
    tick();
    tick();
    check("midwb_we", {15'h0, rf_we}, 16'h0001);
    rst_n = 1'b0;
    tick();
    check("midwb_rst_we",  {15'h0, rf_we},     16'h0000);
    check("midwb_rst_pc",  {8'h00, imem_addr}, 16'h0000);
    check("midwb_rst_req", {15'h0, imem_req},  16'h0000);
    rst_n = 1'b1;
    tick();
    check("midwb_req",  {15'h0, imem_req},  16'h0001);
    check("midwb_addr", {8'h00, imem_addr}, 16'h0000);

    // HALT is absorbing.
    fetch(16'hF000);
    tick();
    tick();
    check("halt_halted", {15'h0, halted},   16'h0001);
    check("halt_req",    {15'h0, imem_req}, 16'h0000);
    imem_ack   = 1'b1;
    imem_rdata = 16'h0298;
    set_alu_flags(4'b1111);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_hold_halted", {15'h0, halted},    16'h0001);
      check("halt_hold_req",    {15'h0, imem_req},  16'h0000);
      check("halt_hold_we",     {15'h0, rf_we},     16'h0000);
      check("halt_hold_pc",     {8'h00, imem_addr}, 16'h0001);
      check("halt_hold_flags",  {12'h000, flags},   16'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-004 SHALL have port imem_addr, output, 8 bits: fetch address; equals pc.
REQ-005 SHALL have port imem_ack, input, 1 bit: fetch data valid; sampled only in FETCH.
REQ-006 SHALL have port imem_rdata, input, 16 bits: instruction word, valid with imem_ack.
REQ-007 SHALL have port rf_raddr_a, output, 3 bits: register-file read port A, driven from ir[8:6].
REQ-008 SHALL have port rf_raddr_b, output, 3 bits: register-file read port B, driven from ir[5:3].
REQ-009 SHALL have port alu_op, output, 3 bits: ALU operation code driven to the 8-bit ALU.
REQ-010 SHALL have port alu_zero, alu_negative, alu_carry, alu_overflow, input, 1 bit each: ALU flag outputs.
REQ-011 SHALL have port rf_we, output, 1 bit: register-file write enable.
REQ-012 SHALL have port rf_waddr, output, 3 bits: write address, driven from ir[11:9].
REQ-013 SHALL have port wb_sel, output, 1 bit: write data source; 0 = ALU result, 1 = imm.
REQ-014 SHALL have port imm, output, 8 bits: immediate, driven from ir[7:0].
REQ-015 SHALL have port flags, output, 4 bits: flag register, ordered {Z,N,C,V}.
REQ-016 SHALL have port halted, output, 1 bit: core stopped.

Function
REQ-017 SHALL decode opcode from ir[15:12]:
- 0x0-0x5: ADD, SUB, AND, OR, XOR, NOT.
- 0x6: LDI.
- 0x7: CMP.
- 0x8: JMP.
- 0x9: BZ.
- 0xA: BN.
- 0xB: BC.
- 0xF: HALT.
- All other opcodes: NOP.
REQ-018 SHALL drive alu_op as follows:
- opcodes 0x0-0x5: ir[14:12].
- CMP: 3'b001.
- All other opcodes: 3'b000.
REQ-019 SHALL implement states FETCH, DECODE, EXEC, WB and HALT.
REQ-020 In FETCH, the block SHALL assert imem_req and hold imem_addr stable until imem_ack.
REQ-021 On the cycle imem_ack is seen in FETCH, the block SHALL latch ir from imem_rdata, set pc to pc+1 (modulo 256, so 0xFF wraps to 0x00) and go to DECODE.
REQ-022 DECODE SHALL last exactly one cycle and then go to EXEC.
REQ-023 In EXEC, for ALU opcodes 0x0-0x5 and CMP, the block SHALL latch {alu_zero, alu_negative, alu_carry, alu_overflow} into flags at the end of the cycle.
REQ-024 For all other opcodes, flags SHALL be unchanged.
REQ-025 From EXEC, the block SHALL go to WB for opcodes 0x0-0x6 and to FETCH for CMP, jumps, branches and NOP.
REQ-026 From EXEC, the block SHALL go to HALT for opcode 0xF.
REQ-027 In EXEC, JMP SHALL set pc to imm.
REQ-028 BZ, BN and BC SHALL set pc to imm only if flags Z, N or C respectively is 1, evaluated on the registered flags value before the EXEC edge; otherwise pc is unchanged.
REQ-029 In WB, rf_we SHALL be 1 for exactly one cycle, with wb_sel=1 for LDI and 0 otherwise; the block then goes to FETCH.
REQ-030 rf_we SHALL be 0 in every state other than WB.
REQ-031 imem_req SHALL be 0 in every state other than FETCH.
REQ-032 imem_ack outside FETCH SHALL be ignored.
REQ-033 HALT SHALL be absorbing: halted=1, imem_req=0, rf_we=0, pc and flags frozen, until reset.
REQ-034 Latency with imem_ack in the first FETCH cycle SHALL be:
- 4 cycles per ALU or LDI instruction.
- 3 cycles per CMP, jump, branch or NOP.

Reset
REQ-035 While rst_n=0 at a clock edge, the block SHALL set state=FETCH, pc=0x00, ir=0x0000, flags=4'b0000, halted=0.
REQ-036 During that reset cycle, the block SHALL drive imem_req=0 and rf_we=0.
REQ-037 Reset asserted in any state, including mid-WB, SHALL abort the instruction with no register write after the reset edge.
REQ-038 The first imem_req SHALL be at address 0x00 in the first cycle after rst_n returns to 1.

Verification
REQ-039 The bench SHALL cover reset: rst_n=0 for 2 cycles -> pc=0, flags=0, rf_we=0, halted=0; next cycle imem_req=1 with imem_addr=0x00.
REQ-040 The bench SHALL cover ADD: instruction 0x0298 (ADD r1,r2,r3) with immediate ack and ALU flags Z=1 -> rf_raddr_a=2, rf_raddr_b=3, alu_op=000, flags=4'b1000, and on cycle 4 rf_we=1, rf_waddr=1, wb_sel=0.
REQ-041 The bench SHALL cover LDI: instruction 0x6AA5 -> rf_we=1, rf_waddr=5, wb_sel=1, imm=0xA5, flags unchanged.
REQ-042 The bench SHALL cover branches: CMP with alu_zero=1 followed by BZ 0x9040 -> next imem_addr=0x40; repeat with alu_zero=0 -> imem_addr sequential.
REQ-043 The bench SHALL cover delayed ack and wrap: imem_ack delayed 3 cycles -> imem_req held and imem_addr stable; ack at pc=0xFF -> pc=0x00.
REQ-044 The bench SHALL cover HALT and reset mid-WB: instruction 0xF000 -> halted=1 and imem_req=0 permanently; separately, rst_n=0 during WB -> rf_we=0 from the next cycle, pc=0.
